axis_pid: RTL and testbench

//  Single-axis PID stage downstream of inert_intf: consumes one fusion-corrected angle (ptch, roll or yaw) plus its vld strobe.

---
 rtl/pid_pkg.sv | 33 +++
 rtl/axis_pid_d_queue.sv | 38 +++
 rtl/axis_pid.sv | 102 ++++++++++
 tb/tb_axis_pid.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pid_pkg.sv
// Shared widths, saturation limits and the saturate helper for the single-axis PID stage.
package pid_pkg;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned DIFF_W   = 17;
    localparam int unsigned ERR_W    = 10;
    localparam int unsigned D_DIFF_W = 7;
    localparam int unsigned INTEG_W  = 18;
    localparam int unsigned CNTRL_W  = 11;
    localparam int unsigned P_W      = 14;
    localparam int unsigned D_W      = 12;
    localparam int unsigned SUM_W    = 15;

    localparam int ERR_MAX    = 511;
    localparam int ERR_MIN    = -512;
    localparam int D_DIFF_MAX = 63;
    localparam int D_DIFF_MIN = -64;
    localparam int INTEG_MAX  = 131071;
    localparam int INTEG_MIN  = -131072;
    localparam int CNTRL_MAX  = 1023;
    localparam int CNTRL_MIN  = -1024;

    // Clamp a wide signed value into [lo, hi]; caller narrows the result to the target width.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int lo, input int hi);
        if (val > hi)
            return hi;
        else if (val < lo)
            return lo;
        return val;
    endfunction

endpackage

// File: rtl/axis_pid_d_queue.sv
// Shift register of past saturated errors; oldest entry feeds the derivative difference.
module d_queue
    import pid_pkg::*;
#(
    parameter int unsigned DEPTH = 12
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    push,
    input  logic signed [ERR_W-1:0] din,
    output logic                    full,
    output logic signed [ERR_W-1:0] oldest
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic signed [ERR_W-1:0] q [DEPTH];
    logic [CNT_W-1:0]        fill;

    // Fill count saturates at DEPTH; full is registered alongside it.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) q[i] <= '0;
            fill <= '0;
            full <= 1'b0;
        end else if (push) begin
            q[0] <= din;
            for (int i = 1; i < DEPTH; i++) q[i] <= q[i-1];
            if (!full) begin
                fill <= fill + CNT_W'(1);
                full <= (fill == CNT_W'(DEPTH - 1));
            end
        end
    end

    assign oldest = q[DEPTH-1];

endmodule

// File: rtl/axis_pid.sv
// Single-axis PID: error capture, P/I/D term stage, sum stage, saturated output register.
module axis_pid
    import pid_pkg::*;
#(
    parameter int unsigned P_COEFF       = 6,
    parameter int unsigned D_COEFF       = 7,
    parameter int unsigned D_QUEUE_DEPTH = 12,
    parameter int unsigned I_SHIFT       = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      vld,
    input  logic signed [DATA_W-1:0]  actual,
    input  logic signed [DATA_W-1:0]  desired,
    output logic signed [CNTRL_W-1:0] cntrl,
    output logic                      cntrl_vld
);

    logic clr;
    logic s1_vld, s2_vld, s3_vld;
    logic signed [ERR_W-1:0]    s1_err;
    logic signed [P_W-1:0]      s2_p;
    logic signed [D_W-1:0]      s2_d;
    logic signed [INTEG_W-1:0]  s2_i;
    logic signed [INTEG_W-1:0]  integ;
    logic signed [SUM_W-1:0]    s3_sum;

    logic signed [DIFF_W-1:0]   diff_c;
    logic signed [ERR_W-1:0]    err_sat_c;
    logic signed [D_DIFF_W-1:0] d_diff_c;
    logic signed [P_W-1:0]      p_term_c;
    logic signed [D_W-1:0]      d_term_c;
    logic signed [INTEG_W-1:0]  integ_next_c;
    logic signed [INTEG_W-1:0]  i_term_c;
    logic signed [SUM_W-1:0]    sum_c;
    logic signed [CNTRL_W-1:0]  cntrl_c;

    logic                       q_full;
    logic signed [ERR_W-1:0]    q_oldest;

    // Reset and disable both flush every stage, the integrator and the history.
    assign clr = rst | ~en;

    d_queue #(.DEPTH(D_QUEUE_DEPTH)) u_d_queue (
        .clk    (clk),
        .clr    (clr),
        .push   (s1_vld),
        .din    (s1_err),
        .full   (q_full),
        .oldest (q_oldest)
    );

    always_comb begin
        diff_c       = DIFF_W'(actual) - DIFF_W'(desired);
        err_sat_c    = ERR_W'(sat_signed(32'(diff_c), ERR_MIN, ERR_MAX));
        d_diff_c     = D_DIFF_W'(sat_signed(32'(s1_err) - 32'(q_oldest), D_DIFF_MIN, D_DIFF_MAX));
        p_term_c     = P_W'(32'(s1_err) * $signed(32'(P_COEFF)));
        d_term_c     = '0;
        if (q_full)
            d_term_c = D_W'(32'(d_diff_c) * $signed(32'(D_COEFF)));
        integ_next_c = INTEG_W'(sat_signed(32'(integ) + 32'(s1_err), INTEG_MIN, INTEG_MAX));
        i_term_c     = integ_next_c >>> I_SHIFT;
        sum_c        = SUM_W'(32'(s2_p) + 32'(s2_d) + 32'(s2_i));
        cntrl_c      = CNTRL_W'(sat_signed(32'(s3_sum), CNTRL_MIN, CNTRL_MAX));
    end

    // Pipeline registers; data fields only load on their stage valid so cntrl holds between samples.
    always_ff @(posedge clk) begin
        if (clr) begin
            s1_vld    <= 1'b0;
            s1_err    <= '0;
            s2_vld    <= 1'b0;
            s2_p      <= '0;
            s2_d      <= '0;
            s2_i      <= '0;
            integ     <= '0;
            s3_vld    <= 1'b0;
            s3_sum    <= '0;
            cntrl     <= '0;
            cntrl_vld <= 1'b0;
        end else begin
            s1_vld    <= vld;
            s2_vld    <= s1_vld;
            s3_vld    <= s2_vld;
            cntrl_vld <= s3_vld;
            if (vld)
                s1_err <= err_sat_c;
            if (s1_vld) begin
                s2_p  <= p_term_c;
                s2_d  <= d_term_c;
                s2_i  <= i_term_c;
                integ <= integ_next_c;
            end
            if (s2_vld)
                s3_sum <= sum_c;
            if (s3_vld)
                cntrl <= cntrl_c;
        end
    end

endmodule

// File: tb/tb_axis_pid.sv
// Directed bench for axis_pid: stimulus queues expected outputs, a negedge monitor scores them.
module tb_axis_pid;

    logic               clk = 1'b0;
    logic               rst, en, vld;
    logic signed [15:0] actual, desired;
    logic signed [10:0] cntrl;
    logic               cntrl_vld;

    typedef struct {
        logic signed [10:0] val;
        int                 cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    axis_pid dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .vld       (vld),
        .actual    (actual),
        .desired   (desired),
        .cntrl     (cntrl),
        .cntrl_vld (cntrl_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every output pulse must match the head of the queue, value and cycle.
    always @(negedge clk) begin
        if (cntrl_vld) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_vld: cntrl=%0d at cycle %0d, required no output", cntrl, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if (cntrl !== mon_e.val || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL cntrl_out: got %0d at cycle %0d, required %0d at cycle %0d",
                             cntrl, cyc, mon_e.val, mon_e.cyc);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic send(input logic signed [15:0] a, input logic signed [15:0] d, input int expv);
        exp_t e;
        @(negedge clk);
        vld     = 1'b1;
        actual  = a;
        desired = d;
        e.val   = 11'(expv);
        e.cyc   = cyc + 4;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0;
        end
    endtask

    // Drain the pipeline, then pulse en low to clear integrator and history.
    task automatic restart();
        idle(6);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        check("en_low_cntrl", int'(cntrl), 0);
        en = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; vld = 1'b1; actual = 16'sd100; desired = 16'sd0;
        @(negedge clk);
        @(negedge clk);
        check("reset_cntrl", int'(cntrl), 0);
        check("reset_vld", int'(cntrl_vld), 0);
        rst = 1'b0;
        vld = 1'b0;
        idle(6);
        check("post_reset_cntrl", int'(cntrl), 0);

        // Basic P + I with empty history, then cntrl must hold.
        send(16'sd100, 16'sd0, 601);
        idle(8);
        check("hold_cntrl", int'(cntrl), 601);

        // Error saturation both ways.
        restart();
        send(16'sh7FFF, 16'sh8000, 1023);
        restart();
        send(16'sh8000, 16'sh7FFF, -1024);

        // Derivative after a full history of zeros, then the 50 leaving the window.
        restart();
        for (int i = 0; i < 12; i++) send(16'sd0, 16'sd0, 0);
        send(16'sd50, 16'sd0, 650);
        for (int i = 0; i < 11; i++) send(16'sd0, 16'sd0, 0);
        send(16'sd0, 16'sd0, -350);
        send(16'sd500, 16'sd0, 1023);

        // d_diff saturation visible in the output: p=420, d=441, i=1.
        restart();
        for (int i = 0; i < 12; i++) send(16'sd0, 16'sd0, 0);
        send(16'sd70, 16'sd0, 862);

        // en drop discards the in-flight sample and clears state.
        idle(6);
        @(negedge clk);
        vld = 1'b1; actual = 16'sd100; desired = 16'sd0;
        @(negedge clk);
        vld = 1'b0; en = 1'b0;
        repeat (3) @(negedge clk);
        check("en_drop_cntrl", int'(cntrl), 0);
        check("en_drop_vld", int'(cntrl_vld), 0);
        en = 1'b1;
        send(16'sd100, 16'sd0, 601);

        // Back-to-back samples, integrator 100/200/300.
        restart();
        send(16'sd100, 16'sd0, 601);
        send(16'sd100, 16'sd0, 603);
        send(16'sd100, 16'sd0, 604);

        // Long run at err=511: integrator must pin at max, never wrap.
        restart();
        for (int i = 0; i < 2000; i++) send(16'sd511, 16'sd0, 1023);
        idle(8);

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
